// File: rtl/fpalu_request_driver_pkg.sv
// -----------------------------------------------------------------------------
// fpalu_pkg
// Shared definitions for the floating_point_alu request driver:
//   - datapath widths (IEEE-754 double, 3-bit ALU mode)
//   - ALU mode encoding and legality helper
//   - response status bit positions
//   - driver FSM state encoding
//   - NaN detector on the magnitude bits of a double
// -----------------------------------------------------------------------------
package fpalu_pkg;

    localparam int DATA_W   = 64;
    localparam int MODE_W   = 3;
    localparam int STATUS_W = 4;
    localparam int MANT_W   = 52;

    typedef enum logic [MODE_W-1:0] {
        FP_ADD  = 3'b000,
        FP_SUB  = 3'b001,
        FP_MUL  = 3'b010,
        FP_DIV  = 3'b011,
        FP_SQRT = 3'b100
    } fpalu_mode_e;

    // Bit positions inside rsp_status
    localparam int ST_DIV_BY_ZERO  = 0;
    localparam int ST_INVALID_SQRT = 1;
    localparam int ST_ILLEGAL_MODE = 2;
    localparam int ST_NAN_INPUT    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } drv_state_e;

    // Encodings above FP_SQRT have no ALU operation behind them.
    function automatic logic mode_is_legal(input logic [MODE_W-1:0] mode);
        return mode <= FP_SQRT;
    endfunction

    // Takes the value without its sign bit: exponent all ones, mantissa nonzero.
    function automatic logic is_nan(input logic [DATA_W-2:0] mag);
        return (&mag[DATA_W-2:MANT_W]) && (|mag[MANT_W-1:0]);
    endfunction

endpackage

// File: rtl/fpalu_request_driver_if.sv
// -----------------------------------------------------------------------------
// fpalu_request_driver_if
// Command (valid/ready) and response (valid/ready) channels of the ALU
// request driver.
//   master : the initiator (CPU, DMA, test logic) issuing commands
//   slave  : the driver accepting commands and returning responses
// -----------------------------------------------------------------------------
interface fpalu_request_driver_if #(
    parameter int TAG_W = 4
);
    // command channel
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [fpalu_pkg::MODE_W-1:0] cmd_mode;
    logic [fpalu_pkg::DATA_W-1:0] cmd_a;
    logic [fpalu_pkg::DATA_W-1:0] cmd_b;
    logic [TAG_W-1:0]             cmd_tag;

    // response channel
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [fpalu_pkg::DATA_W-1:0]   rsp_result;
    logic [TAG_W-1:0]               rsp_tag;
    logic [fpalu_pkg::STATUS_W-1:0] rsp_status;

    modport master (
        output cmd_valid, cmd_mode, cmd_a, cmd_b, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_tag, rsp_status
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_a, cmd_b, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_tag, rsp_status
    );

endinterface

// File: rtl/fpalu_operand_classifier.sv
// -----------------------------------------------------------------------------
// fpalu_operand_classifier
// Combinational status flags for an incoming command.
//   mode   : ALU mode of the command
//   a      : operand A (full double, sign needed for the sqrt check)
//   b_mag  : operand B without its sign bit (sign never affects a flag)
//   status : [0] div_by_zero [1] invalid_sqrt [2] illegal_mode [3] nan_input
// An illegal mode reports only the illegal_mode flag.
// -----------------------------------------------------------------------------
module fpalu_operand_classifier
    import fpalu_pkg::*;
(
    input  logic [MODE_W-1:0]   mode,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-2:0]   b_mag,
    output logic [STATUS_W-1:0] status
);

    always_comb begin
        status = '0;
        if (!mode_is_legal(mode)) begin
            status[ST_ILLEGAL_MODE] = 1'b1;
        end else begin
            // +0 and -0 both divide by zero, hence the magnitude-only test.
            status[ST_DIV_BY_ZERO]  = (mode == FP_DIV) && (b_mag == '0);
            // -0 is a valid sqrt input; any other negative value is not.
            status[ST_INVALID_SQRT] = (mode == FP_SQRT) && a[DATA_W-1]
                                      && (a[DATA_W-2:0] != '0);
            // sqrt ignores operand B, so a NaN there is not reported.
            status[ST_NAN_INPUT]    = is_nan(a[DATA_W-2:0])
                                      || ((mode != FP_SQRT) && is_nan(b_mag));
        end
    end

endmodule

// File: rtl/fpalu_request_driver.sv
// -----------------------------------------------------------------------------
// fpalu_request_driver
// Initiator-side front end for floating_point_alu. Accepts one command at a
// time, drives the ALU operand/mode inputs, waits the fixed ALU latency,
// picks the ALU result port that matches the mode and returns it with the
// command tag and status flags.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : cmd_* valid/ready command, rsp_* valid/ready response
//   alu_mode/operand_*  : registered drive into the ALU
//   alu_result_*        : ALU result ports (div also carries sqrt)
// Timing: rsp_valid rises ALU_LATENCY edges after the accept edge; an
// illegal mode responds on the edge right after the accept.
// -----------------------------------------------------------------------------
module fpalu_request_driver
    import fpalu_pkg::*;
#(
    parameter int TAG_W       = 4,
    parameter int ALU_LATENCY = 4   // legal range 1..15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpalu_request_driver_if.slave bus,
    output logic [MODE_W-1:0]    alu_mode,
    output logic [DATA_W-1:0]    alu_operand_a,
    output logic [DATA_W-1:0]    alu_operand_b,
    input  logic [DATA_W-1:0]    alu_result_add_sub,
    input  logic [DATA_W-1:0]    alu_result_mul,
    input  logic [DATA_W-1:0]    alu_result_div
);

    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY - 1);

    drv_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic                valid_q, valid_d;

    logic [STATUS_W-1:0] cmd_status;
    logic [DATA_W-1:0]   alu_result_sel;
    logic                accept;

    fpalu_operand_classifier u_classifier (
        .mode   (bus.cmd_mode),
        .a      (bus.cmd_a),
        .b_mag  (bus.cmd_b[DATA_W-2:0]),
        .status (cmd_status)
    );

    // Result port for the command in flight; mode_q is stable through WAIT.
    always_comb begin
        case (mode_q)
            FP_ADD, FP_SUB: alu_result_sel = alu_result_add_sub;
            FP_MUL:         alu_result_sel = alu_result_mul;
            default:        alu_result_sel = alu_result_div;
        endcase
    end

    // ready_q is only ever set while IDLE, so it doubles as the IDLE qualifier.
    assign accept = ready_q && bus.cmd_valid;

    always_comb begin
        // NOTE: every variable assigned here gets a hold-value default first,
        // so no branch can leave one unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        tag_d    = tag_q;
        status_d = status_q;
        valid_d  = valid_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    tag_d    = bus.cmd_tag;
                    status_d = cmd_status;
                    if (cmd_status[ST_ILLEGAL_MODE]) begin
                        // No ALU operation: answer at once, ALU inputs untouched.
                        result_d = '0;
                        valid_d  = 1'b1;
                        state_d  = RESP;
                    end else begin
                        mode_d  = bus.cmd_mode;
                        a_d     = bus.cmd_a;
                        b_d     = bus.cmd_b;
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    result_d = alu_result_sel;
                    valid_d  = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    // NOTE: the datapath registers are reset too, not just the control,
    // because the ALU inputs and response fields must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            mode_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            tag_q    <= '0;
            status_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            status_q <= status_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.cmd_ready  = ready_q;
    assign bus.rsp_valid  = valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_tag    = tag_q;
    assign bus.rsp_status = status_q;

    assign alu_mode      = mode_q;
    assign alu_operand_a = a_q;
    assign alu_operand_b = b_q;

endmodule

// File: tb/tb_fpalu_request_driver.sv
// -----------------------------------------------------------------------------
// tb_fpalu_request_driver
// Bench for fpalu_request_driver with ALU_LATENCY=4. A behavioural ALU
// (real arithmetic behind a register pipeline) feeds the result ports; the
// expected response of every command is computed from its mode and operands.
// -----------------------------------------------------------------------------
module tb_fpalu_request_driver;
    import fpalu_pkg::*;

    localparam int TAG_W = 4;
    localparam int L     = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fpalu_request_driver_if #(.TAG_W(TAG_W)) bus ();

    logic [MODE_W-1:0] alu_mode;
    logic [63:0]       alu_operand_a, alu_operand_b;
    logic [63:0]       alu_result_add_sub, alu_result_mul, alu_result_div;

    fpalu_request_driver #(.TAG_W(TAG_W), .ALU_LATENCY(L)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .bus                (bus),
        .alu_mode           (alu_mode),
        .alu_operand_a      (alu_operand_a),
        .alu_operand_b      (alu_operand_b),
        .alu_result_add_sub (alu_result_add_sub),
        .alu_result_mul     (alu_result_mul),
        .alu_result_div     (alu_result_div)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ALU inputs the bench expects to see: those of the last legal command
    logic [2:0]  last_mode;
    logic [63:0] last_a, last_b;

    // op: 0 add, 1 sub, 2 mul, 3 div, 4 sqrt
    function automatic logic [63:0] fp_calc(input int op, input logic [63:0] a, input logic [63:0] b);
        real x, y, r;
        x = $bitstoreal(a);
        y = $bitstoreal(b);
        case (op)
            0:       r = x + y;
            1:       r = x - y;
            2:       r = x * y;
            3:       r = x / y;
            default: r = $sqrt(x);
        endcase
        return $realtobits(r);
    endfunction

    // ---- behavioural ALU: L-1 register stages after the driver's own register
    logic [63:0] as_p [L-1];
    logic [63:0] mul_p[L-1];
    logic [63:0] div_p[L-1];

    always @(posedge clk) begin
        as_p[0]  <= fp_calc((alu_mode == 3'd1) ? 1 : 0, alu_operand_a, alu_operand_b);
        mul_p[0] <= fp_calc(2, alu_operand_a, alu_operand_b);
        div_p[0] <= fp_calc((alu_mode == 3'd4) ? 4 : 3, alu_operand_a, alu_operand_b);
        for (int i = 1; i < L - 1; i++) begin
            as_p[i]  <= as_p[i-1];
            mul_p[i] <= mul_p[i-1];
            div_p[i] <= div_p[i-1];
        end
    end

    assign alu_result_add_sub = as_p[L-2];
    assign alu_result_mul     = mul_p[L-2];
    assign alu_result_div     = div_p[L-2];

    // ---- reference model of the response
    function automatic logic [63:0] ref_result(input logic [2:0] mode, input logic [63:0] a, input logic [63:0] b);
        if (mode > 3'd4) return 64'h0;
        return fp_calc(int'(mode), a, b);
    endfunction

    function automatic logic [3:0] ref_status(input logic [2:0] mode, input logic [63:0] a, input logic [63:0] b);
        logic [3:0] s;
        logic       a_nan, b_nan;
        if (mode > 3'd4) return 4'b0100;
        a_nan = (a[62:52] == 11'h7FF) && (a[51:0] != 52'h0);
        b_nan = (b[62:52] == 11'h7FF) && (b[51:0] != 52'h0);
        s    = 4'b0000;
        s[0] = (mode == 3'd3) && (b[62:0] == 63'h0);
        s[1] = (mode == 3'd4) && a[63] && (a[62:0] != 63'h0);
        s[3] = a_nan || ((mode != 3'd4) && b_nan);
        return s;
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'h0;
            1:       v = 64'h8000_0000_0000_0000;
            2:       v = {1'($urandom_range(0, 1)), 11'h7FF, 20'($urandom) | 20'h1, 32'($urandom)};
            3:       v = {1'($urandom_range(0, 1)), 11'h7FF, 52'h0};
            default: v = {32'($urandom), 32'($urandom)};
        endcase
        return v;
    endfunction

    // ---- drive one command through to its response handshake.
    // lat counts cycles from the accept cycle (0) to the first rsp_valid cycle.
    task automatic run_cmd(input logic [2:0] mode, input logic [63:0] a, input logic [63:0] b,
                           input logic [3:0] tag, input int hold,
                           output int lat, output logic [63:0] res,
                           output logic [3:0] tg, output logic [3:0] st);
        int guard;
        lat = -1; res = '0; tg = '0; st = '0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = mode;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_tag   = tag;
        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.cmd_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: cmd_ready=%0b after %0d cycles, required 1", bus.cmd_ready, guard);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (mode <= 3'd4) begin
            last_mode = mode; last_a = a; last_b = b;
        end
        lat = 1;
        while (!bus.rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.rsp_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout: rsp_valid=0 after %0d cycles, required 1", lat);
            return;
        end
        repeat (hold) @(negedge clk);
        res = bus.rsp_result;
        tg  = bus.rsp_tag;
        st  = bus.rsp_status;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    // ---- scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_mode = '0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.cmd_tag = '0; bus.rsp_ready = 1'b0;
        last_mode = '0; last_a = '0; last_b = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.cmd_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_cmd_ready: got %0b, required 0", bus.cmd_ready);
        end
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_status} !== '0) begin
            n_bad++; $display("FAIL reset_rsp: valid=%0b result=%h tag=%h status=%b, required all 0",
                              bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_status);
        end
        n_cmp++;
        if ({alu_mode, alu_operand_a, alu_operand_b} !== '0) begin
            n_bad++; $display("FAIL reset_alu: mode=%0d a=%h b=%h, required all 0",
                              alu_mode, alu_operand_a, alu_operand_b);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_release_ready: got %0b, required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_add();
        int lat; logic [63:0] res; logic [3:0] tg, st;
        run_cmd(3'd0, 64'h4034800000000000, 64'h4016000000000000, 4'd3, 0, lat, res, tg, st);
        n_cmp++;
        if (lat != L + 1) begin n_bad++; $display("FAIL add_latency: got %0d, required %0d", lat, L + 1); end
        n_cmp++;
        if (res !== 64'h403A000000000000) begin n_bad++; $display("FAIL add_result: got %h, required 403a000000000000", res); end
        n_cmp++;
        if ({tg, st} !== {4'd3, 4'b0000}) begin n_bad++; $display("FAIL add_tag_status: got tag %0d status %b, required 3 0000", tg, st); end
    endtask

    task automatic test_div();
        int lat; logic [63:0] res; logic [3:0] tg, st;
        run_cmd(3'd3, 64'h4059400000000000, 64'hC024000000000000, 4'd7, 1, lat, res, tg, st);
        n_cmp++;
        if (res !== 64'hC024333333333333) begin n_bad++; $display("FAIL div_result: got %h, required c024333333333333", res); end
        n_cmp++;
        if ({tg, st} !== {4'd7, 4'b0000}) begin n_bad++; $display("FAIL div_tag_status: got tag %0d status %b, required 7 0000", tg, st); end
    endtask

    task automatic test_flags();
        int lat; logic [63:0] res; logic [3:0] tg, st;
        run_cmd(3'd3, 64'h4054200000000000, 64'h8000000000000000, 4'd1, 0, lat, res, tg, st);
        n_cmp++;
        if (st !== 4'b0001) begin n_bad++; $display("FAIL div0_status: got %b, required 0001", st); end
        n_cmp++;
        if (res !== ref_result(3'd3, 64'h4054200000000000, 64'h8000000000000000)) begin
            n_bad++; $display("FAIL div0_result: got %h, required %h", res,
                              ref_result(3'd3, 64'h4054200000000000, 64'h8000000000000000));
        end
        run_cmd(3'd4, 64'hC054200000000000, 64'h4000000000000000, 4'd2, 0, lat, res, tg, st);
        n_cmp++;
        if (st !== 4'b0010) begin n_bad++; $display("FAIL sqrt_neg_status: got %b, required 0010", st); end
        n_cmp++;
        if (lat != L + 1) begin n_bad++; $display("FAIL sqrt_latency: got %0d, required %0d", lat, L + 1); end
    endtask

    task automatic test_illegal();
        int lat; logic [63:0] res; logic [3:0] tg, st;
        logic [2:0] pm; logic [63:0] pa, pb;
        pm = last_mode; pa = last_a; pb = last_b;
        run_cmd(3'b110, 64'h3FF0000000000000, 64'h4000000000000000, 4'd9, 0, lat, res, tg, st);
        n_cmp++;
        if (lat != 1) begin n_bad++; $display("FAIL illegal_latency: got %0d, required 1", lat); end
        n_cmp++;
        if ({res, tg, st} !== {64'h0, 4'd9, 4'b0100}) begin
            n_bad++; $display("FAIL illegal_rsp: got result %h tag %0d status %b, required 0 9 0100", res, tg, st);
        end
        n_cmp++;
        if ({alu_mode, alu_operand_a, alu_operand_b} !== {pm, pa, pb}) begin
            n_bad++; $display("FAIL illegal_alu_held: got %0d %h %h, required %0d %h %h",
                              alu_mode, alu_operand_a, alu_operand_b, pm, pa, pb);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a1, b1, a2, b2, r0;
        logic [3:0]  t0, s0;
        bit          stable, ready_low;
        int          lat;
        a1 = 64'h4008000000000000; b1 = 64'h401C000000000000;   // 3.0 * 7.0
        a2 = 64'h4024000000000000; b2 = 64'h3FF8000000000000;   // 10.0 - 1.5
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_mode = 3'd2; bus.cmd_a = a1; bus.cmd_b = b1; bus.cmd_tag = 4'd5;
        @(posedge clk);
        @(negedge clk);
        last_mode = 3'd2; last_a = a1; last_b = b1;
        // second command stays pending from here on
        bus.cmd_mode = 3'd1; bus.cmd_a = a2; bus.cmd_b = b2; bus.cmd_tag = 4'd6;
        ready_low = 1'b1;
        lat = 1;
        while (!bus.rsp_valid && lat < 50) begin
            if (bus.cmd_ready) ready_low = 1'b0;
            @(negedge clk);
            lat++;
        end
        r0 = bus.rsp_result; t0 = bus.rsp_tag; s0 = bus.rsp_status;
        n_cmp++;
        if ({bus.rsp_valid, r0, t0} !== {1'b1, 64'h4035000000000000, 4'd5}) begin
            n_bad++; $display("FAIL bp_first_rsp: got valid %0b result %h tag %0d, required 1 4035000000000000 5",
                              bus.rsp_valid, r0, t0);
        end
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) ready_low = 1'b0;
            if ({bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_status} !== {1'b1, r0, t0, s0})
                stable = 1'b0;
        end
        n_cmp++;
        if (stable !== 1'b1) begin n_bad++; $display("FAIL bp_rsp_stable: got %0b, required 1", stable); end
        n_cmp++;
        if (ready_low !== 1'b1) begin n_bad++; $display("FAIL bp_cmd_ready_low: got %0b, required 1", ready_low); end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n_cmp++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            n_bad++; $display("FAIL bp_after_handshake: got rsp_valid %0b cmd_ready %0b, required 0 1",
                              bus.rsp_valid, bus.cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        last_mode = 3'd1; last_a = a2; last_b = b2;
        n_cmp++;
        if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL bp_pending_accepted: cmd_ready got %0b, required 0", bus.cmd_ready); end
        lat = 1;
        while (!bus.rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if ({lat, bus.rsp_result, bus.rsp_tag} !== {L + 1, 64'h4021000000000000, 4'd6}) begin
            n_bad++; $display("FAIL bp_second_rsp: got lat %0d result %h tag %0d, required %0d 4021000000000000 6",
                              lat, bus.rsp_result, bus.rsp_tag, L + 1);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        bit seen;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_mode = 3'd0;
        bus.cmd_a = 64'h3FF0000000000000; bus.cmd_b = 64'h3FF0000000000000; bus.cmd_tag = 4'd12;
        @(posedge clk);            // accept: counter loads L-1
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(posedge clk);            // counter now 2
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b00) begin
            n_bad++; $display("FAIL midreset_ctrl: got rsp_valid %0b cmd_ready %0b, required 0 0", bus.rsp_valid, bus.cmd_ready);
        end
        n_cmp++;
        if ({alu_mode, alu_operand_a, alu_operand_b} !== '0) begin
            n_bad++; $display("FAIL midreset_alu: got %0d %h %h, required all 0", alu_mode, alu_operand_a, alu_operand_b);
        end
        last_mode = '0; last_a = '0; last_b = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_ready: got %0b, required 1", bus.cmd_ready); end
        seen = 1'b0;
        for (int i = 0; i < L + 6; i++) begin
            if (bus.rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset_no_rsp: rsp_valid seen %0b, required 0", seen); end
    endtask

    task automatic test_random();
        int lat; logic [63:0] res, a, b; logic [3:0] tg, st, tag; logic [2:0] mode;
        for (int n = 0; n < 40; n++) begin
            mode = 3'($urandom_range(0, 7));
            a    = rand_operand();
            b    = rand_operand();
            tag  = 4'($urandom);
            run_cmd(mode, a, b, tag, $urandom_range(0, 3), lat, res, tg, st);
            n_cmp++;
            if (lat != ((mode > 3'd4) ? 1 : L + 1)) begin
                n_bad++; $display("FAIL rnd%0d_latency: mode %0d got %0d", n, mode, lat);
            end
            n_cmp++;
            if ({res, tg, st} !== {ref_result(mode, a, b), tag, ref_status(mode, a, b)}) begin
                n_bad++; $display("FAIL rnd%0d_rsp: mode %0d a %h b %h got %h/%0d/%b, required %h/%0d/%b",
                                  n, mode, a, b, res, tg, st, ref_result(mode, a, b), tag, ref_status(mode, a, b));
            end
            n_cmp++;
            if ({alu_mode, alu_operand_a, alu_operand_b, bus.rsp_valid, bus.cmd_ready}
                !== {last_mode, last_a, last_b, 1'b0, 1'b1}) begin
                n_bad++; $display("FAIL rnd%0d_alu_idle: got %0d %h %h v%0b r%0b, required %0d %h %h v0 r1",
                                  n, alu_mode, alu_operand_a, alu_operand_b, bus.rsp_valid, bus.cmd_ready,
                                  last_mode, last_a, last_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_div();
        test_flags();
        test_illegal();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
